// File: rtl/video_mode_pkg.sv
// Shared mode encodings, switch bit positions and per-mode output decode
// for the video filter/zoom mode controller.
package video_mode_pkg;

    localparam int MODE_NORMAL    = 0;
    localparam int MODE_RED       = 1;
    localparam int MODE_GREEN     = 2;
    localparam int MODE_BLUE      = 3;
    localparam int MODE_GSCALE    = 4;
    localparam int MODE_ZOOM_BASE = 5;

    localparam int SW_RED    = 7;
    localparam int SW_GREEN  = 6;
    localparam int SW_BLUE   = 5;
    localparam int SW_GSCALE = 4;

    localparam logic [2:0] CHAN_ALL   = 3'b111;
    localparam logic [2:0] CHAN_RED   = 3'b100;
    localparam logic [2:0] CHAN_GREEN = 3'b010;
    localparam logic [2:0] CHAN_BLUE  = 3'b001;

    // ZOOM2 is encoded at MODE_ZOOM_BASE, so ZOOMk sits at MODE_ZOOM_BASE + k - 2.
    function automatic int mode_zoom_factor(input int m);
        return (m >= MODE_ZOOM_BASE) ? (m - MODE_ZOOM_BASE + 2) : 1;
    endfunction

    function automatic logic [2:0] mode_chan_mask(input int m);
        case (m)
            MODE_RED:   return CHAN_RED;
            MODE_GREEN: return CHAN_GREEN;
            MODE_BLUE:  return CHAN_BLUE;
            default:    return CHAN_ALL;
        endcase
    endfunction

endpackage

// File: rtl/video_mode_ctrl_sw_debounce.sv
// One-bit switch conditioner: two-flop synchroniser followed by a
// saturating stability counter that gates updates of the accepted level.
module sw_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Counter only runs while the synced level disagrees with the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (sync_p1 == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            db  <= sync_p1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/video_mode_ctrl.sv
// Switch-driven filter/zoom mode controller: debounced switches feed a mode
// FSM whose state is committed to the pixel datapath only at frame_start.
module video_mode_ctrl
    import video_mode_pkg::*;
#(
    parameter  int SW_W      = 10,
    parameter  int NUM_ZOOM  = 3,
    parameter  int DB_CYCLES = 500000,
    localparam int ZSEL_W    = $clog2(NUM_ZOOM + 1),
    localparam int MODE_W    = $clog2(5 + NUM_ZOOM)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SW_W-1:0]   sw,
    input  logic              frame_start,
    output logic [MODE_W-1:0] mode,
    output logic [MODE_W-1:0] pending_mode,
    output logic [ZSEL_W:0]   zoom_factor,
    output logic [2:0]        chan_mask,
    output logic              gscale_en,
    output logic              mode_changed
);

    localparam int ZF_W      = ZSEL_W + 1;
    localparam int MODE_LAST = MODE_ZOOM_BASE + NUM_ZOOM - 1;

    logic              rst_meta;
    logic              rst_sync_n;
    logic [SW_W-1:0]   sw_db;
    logic              sw_db_unused;
    logic [ZSEL_W-1:0] zsel;
    logic [MODE_W-1:0] pending_nxt;
    int                pend_int;
    logic [ZF_W-1:0]   zoom_nxt;
    logic [2:0]        chan_nxt;
    logic              gscale_nxt;

    // Reset asserts immediately, releases on the second clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    for (genvar i = 0; i < SW_W; i++) begin : g_db
        sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk  (clk),
            .rst_n(rst_sync_n),
            .raw  (sw[i]),
            .db   (sw_db[i])
        );
    end

    assign sw_db_unused = ^sw_db;
    assign zsel         = sw_db[SW_W-1 -: ZSEL_W];
    assign pend_int     = int'(pending_mode);

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) pending_mode <= MODE_W'(MODE_NORMAL);
        else             pending_mode <= pending_nxt;
    end

    // From NORMAL the highest-priority request wins; elsewhere only the own bit matters.
    always_comb begin
        pending_nxt = MODE_W'(MODE_NORMAL);
        case (pend_int)
            MODE_NORMAL: begin
                if (zsel != '0)              pending_nxt = MODE_W'(MODE_GSCALE + int'(zsel));
                else if (sw_db[SW_GSCALE])   pending_nxt = MODE_W'(MODE_GSCALE);
                else if (sw_db[SW_BLUE])     pending_nxt = MODE_W'(MODE_BLUE);
                else if (sw_db[SW_GREEN])    pending_nxt = MODE_W'(MODE_GREEN);
                else if (sw_db[SW_RED])      pending_nxt = MODE_W'(MODE_RED);
            end
            MODE_RED:    if (sw_db[SW_RED])    pending_nxt = pending_mode;
            MODE_GREEN:  if (sw_db[SW_GREEN])  pending_nxt = pending_mode;
            MODE_BLUE:   if (sw_db[SW_BLUE])   pending_nxt = pending_mode;
            MODE_GSCALE: if (sw_db[SW_GSCALE]) pending_nxt = pending_mode;
            default: begin
                if (pend_int >= MODE_ZOOM_BASE && pend_int <= MODE_LAST && zsel != '0)
                    pending_nxt = pending_mode;
            end
        endcase
    end

    always_comb begin
        zoom_nxt   = ZF_W'(mode_zoom_factor(pend_int));
        chan_nxt   = mode_chan_mask(pend_int);
        gscale_nxt = (pend_int == MODE_GSCALE);
    end

    // Commit stage: every datapath-facing output moves on the same frame_start edge.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            mode         <= MODE_W'(MODE_NORMAL);
            zoom_factor  <= ZF_W'(1);
            chan_mask    <= CHAN_ALL;
            gscale_en    <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            mode_changed <= frame_start && (pending_mode != mode);
            if (frame_start) begin
                mode        <= pending_mode;
                zoom_factor <= zoom_nxt;
                chan_mask   <= chan_nxt;
                gscale_en   <= gscale_nxt;
            end
        end
    end

endmodule
